writeback_commit: RTL and testbench

- Consumer end of the memory-to-writeback pipeline register: takes the MD_* bundle and retires one instruction per cycle.
- Per retired instruction it:
  - drives the register-file write port;
  - issues a registered branch-predictor training pulse;
  - updates the retire, cycle and mispredict counters;
  - pushes a record into a commit-trace FIFO that is drained by the difftest/trace sink over a valid/ready handshake.
- When the FIFO is full it back-pressures the pipeline through W_stall_o.

---
 rtl/writeback_commit.sv | 150 +++++++++++++++
 tb/tb_writeback_commit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_commit.sv
// Writeback stage: retires one instruction per cycle, writes the register file,
// trains the branch predictor, keeps the retire counters and queues commit-trace records.
module writeback_commit #(
  parameter int XLEN        = 64,
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   MD_commit_i,
  input  logic [INSTR_WIDTH-1:0] MD_instr_i,
  input  logic [PC_WIDTH-1:0]    MD_PC_i,
  input  logic [PC_WIDTH-1:0]    MD_nPC_i,
  input  logic                   MD_sel_reg_i,
  input  logic [XLEN-1:0]        MD_valM_i,
  input  logic [XLEN-1:0]        MD_valE_i,
  input  logic                   MD_need_dstE_i,
  input  logic [4:0]             MD_dstE_i,
  input  logic                   MD_train_vaild_i,
  input  logic                   MD_train_predict_i,
  input  logic                   MD_train_taken_i,
  output logic                   W_stall_o,
  output logic                   W_reg_we_o,
  output logic [4:0]             W_reg_waddr_o,
  output logic [XLEN-1:0]        W_reg_wdata_o,
  output logic                   W_bp_valid_o,
  output logic                   W_bp_taken_o,
  output logic                   W_bp_mispredict_o,
  output logic [PC_WIDTH-1:0]    W_bp_PC_o,
  output logic [63:0]            W_minstret_o,
  output logic [63:0]            W_mcycle_o,
  output logic [31:0]            W_mispred_cnt_o,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [PC_WIDTH-1:0]    trace_PC_o,
  output logic [PC_WIDTH-1:0]    trace_nPC_o,
  output logic [INSTR_WIDTH-1:0] trace_instr_o,
  output logic                   trace_wen_o,
  output logic [4:0]             trace_wdst_o,
  output logic [XLEN-1:0]        trace_wdata_o
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(TRACE_DEPTH);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic [PC_WIDTH-1:0]    r_mem_pc    [TRACE_DEPTH];
  logic [PC_WIDTH-1:0]    r_mem_npc   [TRACE_DEPTH];
  logic [INSTR_WIDTH-1:0] r_mem_instr [TRACE_DEPTH];
  logic                   r_mem_wen   [TRACE_DEPTH];
  logic [4:0]             r_mem_wdst  [TRACE_DEPTH];
  logic [XLEN-1:0]        r_mem_wdata [TRACE_DEPTH];

  logic            r_bp_valid, r_bp_taken, r_bp_mispredict;
  logic [PC_WIDTH-1:0] r_bp_pc;
  logic [63:0]     r_minstret, r_mcycle;
  logic [31:0]     r_mispred_cnt;

  logic            w_acc, w_push, w_pop, w_train, w_mispred;
  logic            w_we;
  logic [XLEN-1:0] w_wdata;

  // Stall comes from the registered count only, so a pop in the full cycle cannot admit a push.
  assign W_stall_o = (r_count == LP_FULL);
  assign w_acc     = MD_commit_i & ~W_stall_o;
  assign w_push    = w_acc;
  assign w_pop     = trace_valid_o & trace_ready_i;
  assign w_train   = w_acc & MD_train_vaild_i;
  assign w_mispred = MD_train_predict_i ^ MD_train_taken_i;

  assign w_wdata = MD_sel_reg_i ? MD_valM_i : MD_valE_i;
  assign w_we    = w_acc & MD_need_dstE_i & (MD_dstE_i != 5'd0);

  assign W_reg_we_o    = w_we;
  assign W_reg_waddr_o = MD_dstE_i;
  assign W_reg_wdata_o = w_wdata;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pc[r_wptr]    <= MD_PC_i;
      r_mem_npc[r_wptr]   <= MD_nPC_i;
      r_mem_instr[r_wptr] <= MD_instr_i;
      r_mem_wen[r_wptr]   <= w_we;
      r_mem_wdst[r_wptr]  <= MD_dstE_i;
      r_mem_wdata[r_wptr] <= w_wdata;
    end
  end

  assign trace_valid_o = (r_count != '0);
  assign trace_PC_o    = r_mem_pc[r_rptr];
  assign trace_nPC_o   = r_mem_npc[r_rptr];
  assign trace_instr_o = r_mem_instr[r_rptr];
  assign trace_wen_o   = r_mem_wen[r_rptr];
  assign trace_wdst_o  = r_mem_wdst[r_rptr];
  assign trace_wdata_o = r_mem_wdata[r_rptr];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_bp_valid      <= 1'b0;
      r_bp_taken      <= 1'b0;
      r_bp_mispredict <= 1'b0;
      r_bp_pc         <= '0;
    end else begin
      r_bp_valid <= w_train;
      if (w_train) begin
        r_bp_taken      <= MD_train_taken_i;
        r_bp_mispredict <= w_mispred;
        r_bp_pc         <= MD_PC_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_minstret    <= '0;
      r_mcycle      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (w_acc)             r_minstret    <= r_minstret + 64'd1;
      if (w_train && w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign W_bp_valid_o      = r_bp_valid;
  assign W_bp_taken_o      = r_bp_taken;
  assign W_bp_mispredict_o = r_bp_mispredict;
  assign W_bp_PC_o         = r_bp_pc;
  assign W_minstret_o      = r_minstret;
  assign W_mcycle_o        = r_mcycle;
  assign W_mispred_cnt_o   = r_mispred_cnt;

endmodule

// File: tb/tb_writeback_commit.sv
// Directed bench for writeback_commit: register write, branch training, counters,
// trace FIFO ordering, stall/back-pressure and asynchronous reset.
module tb_writeback_commit;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        MD_commit_i;
  logic [31:0] MD_instr_i;
  logic [63:0] MD_PC_i, MD_nPC_i;
  logic        MD_sel_reg_i;
  logic [63:0] MD_valM_i, MD_valE_i;
  logic        MD_need_dstE_i;
  logic [4:0]  MD_dstE_i;
  logic        MD_train_vaild_i, MD_train_predict_i, MD_train_taken_i;
  logic        W_stall_o, W_reg_we_o;
  logic [4:0]  W_reg_waddr_o;
  logic [63:0] W_reg_wdata_o;
  logic        W_bp_valid_o, W_bp_taken_o, W_bp_mispredict_o;
  logic [63:0] W_bp_PC_o, W_minstret_o, W_mcycle_o;
  logic [31:0] W_mispred_cnt_o;
  logic        trace_valid_o, trace_ready_i;
  logic [63:0] trace_PC_o, trace_nPC_o;
  logic [31:0] trace_instr_o;
  logic        trace_wen_o;
  logic [4:0]  trace_wdst_o;
  logic [63:0] trace_wdata_o;

  int n_assert = 0;
  int n_fail   = 0;

  writeback_commit dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .MD_commit_i(MD_commit_i), .MD_instr_i(MD_instr_i), .MD_PC_i(MD_PC_i), .MD_nPC_i(MD_nPC_i),
    .MD_sel_reg_i(MD_sel_reg_i), .MD_valM_i(MD_valM_i), .MD_valE_i(MD_valE_i),
    .MD_need_dstE_i(MD_need_dstE_i), .MD_dstE_i(MD_dstE_i),
    .MD_train_vaild_i(MD_train_vaild_i), .MD_train_predict_i(MD_train_predict_i),
    .MD_train_taken_i(MD_train_taken_i),
    .W_stall_o(W_stall_o), .W_reg_we_o(W_reg_we_o), .W_reg_waddr_o(W_reg_waddr_o),
    .W_reg_wdata_o(W_reg_wdata_o), .W_bp_valid_o(W_bp_valid_o), .W_bp_taken_o(W_bp_taken_o),
    .W_bp_mispredict_o(W_bp_mispredict_o), .W_bp_PC_o(W_bp_PC_o),
    .W_minstret_o(W_minstret_o), .W_mcycle_o(W_mcycle_o), .W_mispred_cnt_o(W_mispred_cnt_o),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_PC_o(trace_PC_o), .trace_nPC_o(trace_nPC_o), .trace_instr_o(trace_instr_o),
    .trace_wen_o(trace_wen_o), .trace_wdst_o(trace_wdst_o), .trace_wdata_o(trace_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge and land on the following falling edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic set_instr(input logic [63:0] pc, input logic [4:0] dst, input logic need);
    MD_commit_i    = 1'b1;
    MD_PC_i        = pc;
    MD_nPC_i       = pc + 64'd4;
    MD_instr_i     = pc[31:0] ^ 32'h0000_0013;
    MD_dstE_i      = dst;
    MD_need_dstE_i = need;
  endtask

  initial begin
    rst_n = 1'b0;
    MD_commit_i = 0; MD_instr_i = 0; MD_PC_i = 0; MD_nPC_i = 0;
    MD_sel_reg_i = 0; MD_valM_i = 0; MD_valE_i = 0; MD_need_dstE_i = 0; MD_dstE_i = 0;
    MD_train_vaild_i = 0; MD_train_predict_i = 0; MD_train_taken_i = 0;
    trace_ready_i = 0;
    #2;
    chk("rst_minstret", W_minstret_o, 64'd0);
    chk("rst_mcycle", W_mcycle_o, 64'd0);
    chk("rst_stall", {63'd0, W_stall_o}, 64'd0);
    chk("rst_tvalid", {63'd0, trace_valid_o}, 64'd0);
    chk("rst_bpvalid", {63'd0, W_bp_valid_o}, 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    step(); step(); step();
    chk("mcycle_3", W_mcycle_o, 64'd3);

    // Load retire: valM selected
    set_instr(64'h1000, 5'd5, 1'b1);
    MD_sel_reg_i = 1; MD_valM_i = 64'h55; MD_valE_i = 64'h11;
    #1;
    chk("load_we", {63'd0, W_reg_we_o}, 64'd1);
    chk("load_waddr", {59'd0, W_reg_waddr_o}, 64'd5);
    chk("load_wdata", W_reg_wdata_o, 64'h55);
    step();
    MD_commit_i = 0;
    #1;
    chk("load_tvalid", {63'd0, trace_valid_o}, 64'd1);
    chk("load_tpc", trace_PC_o, 64'h1000);
    chk("load_tnpc", trace_nPC_o, 64'h1004);
    chk("load_twdata", trace_wdata_o, 64'h55);
    chk("load_twen", {63'd0, trace_wen_o}, 64'd1);
    chk("load_tinstr", {32'd0, trace_instr_o}, 64'h0000_1013);
    chk("load_minstret", W_minstret_o, 64'd1);

    // x0 destination, then a bubble
    set_instr(64'h1008, 5'd0, 1'b1);
    MD_sel_reg_i = 0;
    #1;
    chk("x0_we", {63'd0, W_reg_we_o}, 64'd0);
    chk("x0_wdata_valE", W_reg_wdata_o, 64'h11);
    step();
    MD_commit_i = 0; MD_dstE_i = 5'd7;
    #1;
    chk("bubble_we", {63'd0, W_reg_we_o}, 64'd0);
    chk("x0_minstret", W_minstret_o, 64'd2);
    step();
    chk("bubble_minstret", W_minstret_o, 64'd2);
    trace_ready_i = 1;
    step();
    chk("pop1_tpc", trace_PC_o, 64'h1008);
    chk("pop1_twen", {63'd0, trace_wen_o}, 64'd0);
    step();
    chk("pop2_tvalid", {63'd0, trace_valid_o}, 64'd0);
    step();
    chk("emptypop_tvalid", {63'd0, trace_valid_o}, 64'd0);

    // Branch training: mispredict
    set_instr(64'h8000_0010, 5'd0, 1'b0);
    MD_train_vaild_i = 1; MD_train_predict_i = 0; MD_train_taken_i = 1;
    #1;
    chk("br_nopulse_yet", {63'd0, W_bp_valid_o}, 64'd0);
    step();
    MD_commit_i = 0; MD_train_vaild_i = 0;
    chk("br1_valid", {63'd0, W_bp_valid_o}, 64'd1);
    chk("br1_mispred", {63'd0, W_bp_mispredict_o}, 64'd1);
    chk("br1_taken", {63'd0, W_bp_taken_o}, 64'd1);
    chk("br1_pc", W_bp_PC_o, 64'h8000_0010);
    chk("br1_cnt", {32'd0, W_mispred_cnt_o}, 64'd1);
    step();
    chk("br1_pulse_end", {63'd0, W_bp_valid_o}, 64'd0);
    chk("br1_hold_mispred", {63'd0, W_bp_mispredict_o}, 64'd1);
    chk("br1_hold_pc", W_bp_PC_o, 64'h8000_0010);
    // Correct prediction
    set_instr(64'h8000_0020, 5'd0, 1'b0);
    MD_train_vaild_i = 1; MD_train_predict_i = 1; MD_train_taken_i = 1;
    step();
    MD_commit_i = 0;
    chk("br2_valid", {63'd0, W_bp_valid_o}, 64'd1);
    chk("br2_mispred", {63'd0, W_bp_mispredict_o}, 64'd0);
    chk("br2_pc", W_bp_PC_o, 64'h8000_0020);
    chk("br2_cnt", {32'd0, W_mispred_cnt_o}, 64'd1);
    // Training request on a bubble must not pulse
    MD_train_predict_i = 0;
    step();
    MD_train_vaild_i = 0;
    chk("br_bubble_valid", {63'd0, W_bp_valid_o}, 64'd0);
    chk("br_bubble_cnt", {32'd0, W_mispred_cnt_o}, 64'd1);
    chk("br_minstret", W_minstret_o, 64'd4);
    chk("br_tvalid_empty", {63'd0, trace_valid_o}, 64'd0);

    // Mid-run asynchronous reset with 3 entries queued
    trace_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      set_instr(64'h4000 + 64'(i) * 4, 5'd3, 1'b1);
      step();
    end
    MD_commit_i = 0;
    chk("pre_rst_minstret", W_minstret_o, 64'd7);
    chk("pre_rst_tvalid", {63'd0, trace_valid_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {63'd0, trace_valid_o}, 64'd0);
    chk("arst_minstret", W_minstret_o, 64'd0);
    chk("arst_stall", {63'd0, W_stall_o}, 64'd0);
    chk("arst_bp_pc", W_bp_PC_o, 64'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    step();
    chk("post_rst_mcycle", W_mcycle_o, 64'd1);

    // Fill to full, hold the fifth
    for (int i = 0; i < 4; i++) begin
      set_instr(64'h2000 + 64'(i) * 4, 5'd5, 1'b1);
      step();
    end
    chk("full_stall", {63'd0, W_stall_o}, 64'd1);
    set_instr(64'h2010, 5'd5, 1'b1);
    #1;
    chk("stalled_we", {63'd0, W_reg_we_o}, 64'd0);
    step();
    chk("stalled_minstret", W_minstret_o, 64'd4);
    chk("stalled_head", trace_PC_o, 64'h2000);
    trace_ready_i = 1;
    step();
    trace_ready_i = 0;
    chk("unstall", {63'd0, W_stall_o}, 64'd0);
    #1;
    chk("unstall_we", {63'd0, W_reg_we_o}, 64'd1);
    step();
    MD_commit_i = 0;
    chk("held_minstret", W_minstret_o, 64'd5);
    chk("refull_stall", {63'd0, W_stall_o}, 64'd1);
    trace_ready_i = 1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("order_pc%0d", i), trace_PC_o, 64'h2000 + 64'(i) * 4);
      step();
    end
    chk("drain_tvalid", {63'd0, trace_valid_o}, 64'd0);
    chk("drain_minstret", W_minstret_o, 64'd5);

    // Continuous commit with simultaneous push/pop
    for (int i = 0; i < 6; i++) begin
      set_instr(64'h3000 + 64'(i) * 4, 5'd9, 1'b1);
      step();
      chk($sformatf("stream_pc%0d", i), trace_PC_o, 64'h3000 + 64'(i) * 4);
      chk($sformatf("stream_stall%0d", i), {63'd0, W_stall_o}, 64'd0);
    end
    MD_commit_i = 0;
    step();
    chk("stream_tvalid", {63'd0, trace_valid_o}, 64'd0);
    chk("stream_minstret", W_minstret_o, 64'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
